// File: rtl/vga_stream_gen_if.sv
// Video output bundle: pixel clock, syncs, blank and 24-bit colour.
// The master drives everything; the slave side is for sinks and monitors.
interface video_if;
  logic        CLK;
  logic        HS;
  logic        VS;
  logic        BLANK;
  logic [23:0] RGB;

  modport master (output CLK, output HS, output VS, output BLANK, output RGB);
  modport slave  (input  CLK, input  HS, input  VS, input  BLANK, input  RGB);
endinterface

// File: rtl/vga_stream_gen.sv
// VGA-style timing generator with grid, colour-bar, solid and streamed pixel sources.
// Every video output and frame_start is registered one cycle behind the h/v counters.
module vga_stream_gen #(
  parameter int          HDISP     = 800,
  parameter int          VDISP     = 480,
  parameter int          HFP       = 40,
  parameter int          HPULSE    = 48,
  parameter int          HBP       = 40,
  parameter int          VFP       = 13,
  parameter int          VPULSE    = 3,
  parameter int          VBP       = 29,
  parameter logic        HS_POL    = 1'b0,
  parameter logic        VS_POL    = 1'b0,
  parameter int          GRID_LOG2 = 4,
  parameter logic [23:0] UFLOW_RGB = 24'hFF00FF
) (
  input  logic        pixel_clk,
  input  logic        pixel_rst,
  input  logic [1:0]  mode,
  input  logic [23:0] solid_rgb,
  input  logic [23:0] pix_data,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic        underflow,
  input  logic        underflow_clr,
  output logic        frame_start,
  video_if.master     video_ifm
);

  localparam int HTOTAL = HFP + HPULSE + HBP + HDISP;
  localparam int VTOTAL = VFP + VPULSE + VBP + VDISP;
  localparam int HW     = $clog2(HTOTAL) + 1;
  localparam int VW     = $clog2(VTOTAL) + 1;
  localparam int BARW   = HDISP / 8;
  localparam int BCW    = $clog2(BARW) + 1;

  localparam logic [HW-1:0]  H_LAST    = HW'(HTOTAL - 1);
  localparam logic [HW-1:0]  H_SYNC_S  = HW'(HFP);
  localparam logic [HW-1:0]  H_SYNC_E  = HW'(HFP + HPULSE);
  localparam logic [HW-1:0]  H_ACT     = HW'(HFP + HPULSE + HBP);
  localparam logic [VW-1:0]  V_LAST    = VW'(VTOTAL - 1);
  localparam logic [VW-1:0]  V_SYNC_S  = VW'(VFP);
  localparam logic [VW-1:0]  V_SYNC_E  = VW'(VFP + VPULSE);
  localparam logic [VW-1:0]  V_ACT     = VW'(VFP + VPULSE + VBP);
  localparam logic [HW-1:0]  X_MASK    = HW'((1 << GRID_LOG2) - 1);
  localparam logic [VW-1:0]  Y_MASK    = VW'((1 << GRID_LOG2) - 1);
  localparam logic [BCW-1:0] BAR_LAST  = BCW'(BARW - 1);

  logic [HW-1:0]  h_q, h_d;
  logic [VW-1:0]  v_q, v_d;
  logic [1:0]     mode_q, mode_d;
  logic           hs_q, hs_d;
  logic           vs_q, vs_d;
  logic           blank_q, blank_d;
  logic [23:0]    rgb_q, rgb_d;
  logic           frame_start_q, frame_start_d;
  logic           underflow_q, underflow_d;
  logic [BCW-1:0] bar_cnt_q, bar_cnt_d;
  logic [2:0]     bar_idx_q, bar_idx_d;

  logic           active_s;
  logic [HW-1:0]  x_s;
  logic [VW-1:0]  y_s;
  logic [BCW-1:0] cur_cnt_s;
  logic [2:0]     cur_bar_s;
  logic [2:0]     bar_col_s;
  logic           uflow_set_s;

  assign active_s    = (h_q >= H_ACT) && (v_q >= V_ACT);
  assign x_s         = h_q - H_ACT;
  assign y_s         = v_q - V_ACT;
  assign pix_ready   = (mode_q == 2'd3) && active_s && !pixel_rst;
  assign uflow_set_s = pix_ready && !pix_valid;

  // Next-state for counters, mode capture, bar tracking and registered outputs.
  always_comb begin
    h_d           = h_q;
    v_d           = v_q;
    mode_d        = mode_q;
    hs_d          = ~HS_POL;
    vs_d          = ~VS_POL;
    blank_d       = 1'b0;
    rgb_d         = 24'h000000;
    frame_start_d = 1'b0;
    underflow_d   = underflow_q;
    cur_cnt_s     = bar_cnt_q;
    cur_bar_s     = bar_idx_q;
    bar_cnt_d     = bar_cnt_q;
    bar_idx_d     = bar_idx_q;
    bar_col_s     = 3'd0;

    if (h_q == H_LAST) begin
      h_d = {HW{1'b0}};
      if (v_q == V_LAST) begin
        v_d = {VW{1'b0}};
      end else begin
        v_d = v_q + VW'(1);
      end
    end else begin
      h_d = h_q + HW'(1);
      v_d = v_q;
    end

    if ((h_q == {HW{1'b0}}) && (v_q == {VW{1'b0}})) begin
      mode_d        = mode;
      frame_start_d = 1'b1;
    end else begin
      mode_d        = mode_q;
      frame_start_d = 1'b0;
    end

    if ((h_q >= H_SYNC_S) && (h_q < H_SYNC_E)) begin
      hs_d = HS_POL;
    end else begin
      hs_d = ~HS_POL;
    end

    if ((v_q >= V_SYNC_S) && (v_q < V_SYNC_E)) begin
      vs_d = VS_POL;
    end else begin
      vs_d = ~VS_POL;
    end

    // Bar position restarts at the first active pixel so no divider is needed.
    if (x_s == {HW{1'b0}}) begin
      cur_cnt_s = {BCW{1'b0}};
      cur_bar_s = 3'd0;
    end else begin
      cur_cnt_s = bar_cnt_q;
      cur_bar_s = bar_idx_q;
    end

    if (cur_cnt_s == BAR_LAST) begin
      bar_cnt_d = {BCW{1'b0}};
      bar_idx_d = cur_bar_s + 3'd1;
    end else begin
      bar_cnt_d = cur_cnt_s + BCW'(1);
      bar_idx_d = cur_bar_s;
    end
    bar_col_s = 3'd7 - cur_bar_s;

    blank_d = active_s;
    if (active_s) begin
      case (mode_q)
        2'd0: begin
          if (((x_s & X_MASK) == {HW{1'b0}}) || ((y_s & Y_MASK) == {VW{1'b0}})) begin
            rgb_d = 24'hFFFFFF;
          end else begin
            rgb_d = 24'h000000;
          end
        end
        2'd1: rgb_d = {{8{bar_col_s[2]}}, {8{bar_col_s[1]}}, {8{bar_col_s[0]}}};
        2'd2: rgb_d = solid_rgb;
        2'd3: begin
          if (pix_valid) begin
            rgb_d = pix_data;
          end else begin
            rgb_d = UFLOW_RGB;
          end
        end
        default: rgb_d = 24'h000000;
      endcase
    end else begin
      rgb_d = 24'h000000;
    end

    // A new underflow outranks a clear arriving on the same cycle.
    if (uflow_set_s) begin
      underflow_d = 1'b1;
    end else if (underflow_clr) begin
      underflow_d = 1'b0;
    end else begin
      underflow_d = underflow_q;
    end
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) begin
      h_q           <= {HW{1'b0}};
      v_q           <= {VW{1'b0}};
      mode_q        <= 2'd0;
      hs_q          <= ~HS_POL;
      vs_q          <= ~VS_POL;
      blank_q       <= 1'b0;
      rgb_q         <= 24'h000000;
      frame_start_q <= 1'b0;
      underflow_q   <= 1'b0;
      bar_cnt_q     <= {BCW{1'b0}};
      bar_idx_q     <= 3'd0;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      mode_q        <= mode_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      blank_q       <= blank_d;
      rgb_q         <= rgb_d;
      frame_start_q <= frame_start_d;
      underflow_q   <= underflow_d;
      bar_cnt_q     <= bar_cnt_d;
      bar_idx_q     <= bar_idx_d;
    end
  end

  assign video_ifm.CLK   = pixel_clk;
  assign video_ifm.HS    = hs_q;
  assign video_ifm.VS    = vs_q;
  assign video_ifm.BLANK = blank_q;
  assign video_ifm.RGB   = rgb_q;
  assign frame_start     = frame_start_q;
  assign underflow       = underflow_q;

endmodule

// File: doc/vga_stream_gen.md
VGA_STREAM_GEN -- requirements
Module: vga_stream_gen

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- HDISP 800: active pixels per line.
- VDISP 480: active lines per frame.
- HFP 40 / HPULSE 48 / HBP 40: horizontal front porch, sync width and back porch, in pixels.
- VFP 13 / VPULSE 3 / VBP 29: vertical front porch, sync width and back porch, in lines.
- HS_POL 0 / VS_POL 0: asserted sync level.
- GRID_LOG2 4: grid pitch is 2^GRID_LOG2.
- UFLOW_RGB 24'hFF00FF: colour driven on underflow.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- pixel_clk, in, 1: pixel clock.
- pixel_rst, in, 1: reset, asynchronous, active-high.
- mode, in, 2: 0 grid, 1 colour bars, 2 solid, 3 stream.
- solid_rgb, in, 24: colour for mode 2.
- pix_data, in, 24: stream pixel.
- pix_valid, in, 1: stream pixel valid.
- pix_ready, out, 1: stream pixel consumed this cycle.
- underflow, out, 1: sticky underflow flag.
- underflow_clr, in, 1: clears underflow.
- frame_start, out, 1: one-cycle pulse at the first output cycle of a frame.
- video_ifm, video_if.master, -: carries CLK, HS, VS, BLANK and RGB[23:0].

REQ-003 video_ifm.CLK SHALL be driven by pixel_clk.

Function
REQ-004 Counters: HTOTAL=HFP+HPULSE+HBP+HDISP and VTOTAL=VFP+VPULSE+VBP+VDISP.
- h counts 0..HTOTAL-1 every cycle and wraps to 0.
- v increments when h wraps, and wraps to 0 after VTOTAL-1.
- Counter widths SHALL be $clog2(total)+1.

REQ-005 Region order per line/frame SHALL be front porch, sync, back porch, active.
- HS asserted iff HFP<=h<HFP+HPULSE.
- VS asserted iff VFP<=v<VFP+VPULSE.

REQ-006 Active region: active iff h>=HFP+HPULSE+HBP and v>=VFP+VPULSE+VBP.
- x = h-(HFP+HPULSE+HBP).
- y = v-(VFP+VPULSE+VBP).

REQ-007 Output timing:
- All video outputs and frame_start SHALL be registered, exactly 1 cycle after the counter state they describe.
- BLANK SHALL be high during active and low otherwise.

REQ-008 Output levels:
- HS output = HS_POL when asserted, ~HS_POL otherwise.
- VS likewise with VS_POL.

REQ-009 Mode capture: mode SHALL be captured into mode_q only when h==0 and v==0.
- Mode changes mid-frame SHALL take effect at the next frame.

REQ-010 RGB outside active SHALL be 24'h000000.

REQ-011 Grid mode (0): RGB=24'hFFFFFF if x[GRID_LOG2-1:0]==0 or y[GRID_LOG2-1:0]==0, else 24'h000000.

REQ-012 Colour bars mode (1):
- Eight bars of width HDISP/8; HDISP SHALL be a multiple of 8.
- Bar index SHALL come from a bar counter reset at x==0, not a divider.
- Colour = {8{idx[2]},8{idx[1]},8{idx[0]}} with idx = 7-bar, so bar 0 is white and bar 7 is black.

REQ-013 Solid mode (2): RGB = solid_rgb.

REQ-014 Stream mode (3), pix_ready:
- pix_ready SHALL be combinational, high iff mode_q==3 and the counters are in active.
- pix_ready SHALL be low in all other modes and in blanking.

REQ-015 Stream consumption: a pixel is consumed iff pix_ready && pix_valid; the consumed pix_data SHALL appear on RGB 1 cycle later.

REQ-016 Stream underflow:
- On pix_ready && !pix_valid, RGB SHALL be UFLOW_RGB and underflow SHALL set on the next edge.
- Nothing is consumed and the pixel is not retried.

REQ-017 underflow clear/set:
- underflow SHALL clear on the edge after underflow_clr.
- Simultaneous set and clear SHALL leave it set.

REQ-018 frame_start SHALL pulse high for exactly 1 cycle, registered from h==0 && v==0.

Reset
REQ-019 Asynchronous assertion of pixel_rst SHALL force, within the same cycle with no clock edge:
- h=0, v=0, mode_q=0;
- HS=~HS_POL, VS=~VS_POL, BLANK=0, RGB=0;
- frame_start=0, underflow=0.

REQ-020 pix_ready SHALL be 0 during reset.

REQ-021 Reset deasserted mid-frame SHALL restart timing from h=0, v=0; the first frame_start SHALL occur 1 cycle after the first edge with reset low.

Verification
Small test parameters for all scenarios: HDISP=16, VDISP=8, HFP=2, HPULSE=2, HBP=2, VFP=1, VPULSE=1, VBP=1, GRID_LOG2=2, which gives HTOTAL=22 and VTOTAL=11.

REQ-022 Timing, mode 0:
- HS low for output cycles 3-4 of each line.
- BLANK high for output cycles 7-22 of lines 3-10.
- frame_start period = 242 cycles.

REQ-023 Grid, mode 0: line y=0 is all white; line y=1 is white at x=0,4,8,12 and black elsewhere.

REQ-024 Colour bars, mode 1: each active line is 2 pixels per bar, in order FFFFFF, FFFF00, FF00FF, FF0000, 00FFFF, 00FF00, 0000FF, 000000.

REQ-025 Stream, mode 3, with pix_valid held 1 and an incrementing pix_data:
- pix_ready is high for 128 cycles per frame.
- RGB equals the consumed data 1 cycle later.
- Dropping pix_valid for 1 active cycle gives RGB=FF00FF and sets underflow.
- underflow_clr then clears underflow.

REQ-026 Mode change and reset:
- Changing mode from 0 to 2 mid-frame keeps grid output until the next frame_start.
- Asserting pixel_rst mid-line forces outputs to their reset values immediately; timing restarts from h=0, v=0 after release.
